// File: rtl/key_debouncer.sv
// N-channel key conditioner: two-flop sync, stable-count debounce,
// press/release pulses and optional auto-repeat per channel.
module key_debouncer #(
   parameter int N_KEYS          = 4,
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter bit REPEAT_EN       = 1'b0,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [N_KEYS-1:0] Keys_raw,
   output logic [N_KEYS-1:0] Keys_level,
   output logic [N_KEYS-1:0] Press_pulse,
   output logic [N_KEYS-1:0] Release_pulse,
   output logic              Any_press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [N_KEYS-1:0] RAW_IDLE = ACTIVE_LOW ? '1 : '0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DELAY,
      ST_REPEAT
   } rpt_state_t;

   logic [N_KEYS-1:0] sync1;
   logic [N_KEYS-1:0] sync2;
   logic [N_KEYS-1:0] s2;
   logic [N_KEYS-1:0] level_prev;
   logic [N_KEYS-1:0] rise;
   logic [N_KEYS-1:0] rpt_fire;
   logic [N_KEYS-1:0] press_nx;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync1 <= RAW_IDLE;
         sync2 <= RAW_IDLE;
      end else begin
         sync1 <= Keys_raw;
         sync2 <= sync1;
      end
   end

   // s2 is normalised so that 1 always means pressed
   assign s2 = ACTIVE_LOW ? ~sync2 : sync2;

   for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
      logic [CW-1:0] cnt;
      logic          lvl;
      logic          accept;

      assign accept = (s2[g] != lvl) && (cnt == CMAX);
      assign Keys_level[g] = lvl;

      always_ff @(posedge Clk) begin
         if (Reset) begin
            cnt <= '0;
            lvl <= 1'b0;
         end else if (s2[g] == lvl) begin
            cnt <= '0;
         end else if (accept) begin
            cnt <= '0;
            lvl <= s2[g];
         end else begin
            cnt <= cnt + 1'b1;
         end
      end

      if (REPEAT_EN) begin : g_rpt
         localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                               REPEAT_DELAY : REPEAT_PERIOD;
         localparam int RW = $clog2(RMAX + 1);
         localparam logic [RW-1:0] RDLY = RW'(REPEAT_DELAY - 1);
         localparam logic [RW-1:0] RPER = RW'(REPEAT_PERIOD - 1);

         rpt_state_t    st;
         rpt_state_t    st_nx;
         logic [RW-1:0] rc;
         logic [RW-1:0] rc_nx;
         logic          fire;

         always_ff @(posedge Clk) begin
            if (Reset) begin
               st <= ST_IDLE;
               rc <= '0;
            end else begin
               st <= st_nx;
               rc <= rc_nx;
            end
         end

         always_comb begin
            st_nx = st;
            rc_nx = rc;
            fire  = 1'b0;
            // an accepted release wins over any pending repeat
            if (accept && lvl) begin
               st_nx = ST_IDLE;
               rc_nx = '0;
            end else begin
               unique case (st)
                  ST_IDLE: begin
                     if (rise[g]) begin
                        st_nx = ST_DELAY;
                        rc_nx = '0;
                     end
                  end
                  ST_DELAY: begin
                     if (rc == RDLY) begin
                        fire  = 1'b1;
                        st_nx = ST_REPEAT;
                        rc_nx = '0;
                     end else begin
                        rc_nx = rc + 1'b1;
                     end
                  end
                  ST_REPEAT: begin
                     if (rc == RPER) begin
                        fire  = 1'b1;
                        rc_nx = '0;
                     end else begin
                        rc_nx = rc + 1'b1;
                     end
                  end
                  default: begin
                     st_nx = ST_IDLE;
                     rc_nx = '0;
                  end
               endcase
            end
         end

         assign rpt_fire[g] = fire;
      end else begin : g_norpt
         assign rpt_fire[g] = 1'b0;
      end
   end

   assign rise     = Keys_level & ~level_prev;
   assign press_nx = rise | rpt_fire;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         level_prev    <= '0;
         Press_pulse   <= '0;
         Release_pulse <= '0;
         Any_press     <= 1'b0;
      end else begin
         level_prev    <= Keys_level;
         Press_pulse   <= press_nx;
         Release_pulse <= ~Keys_level & level_prev;
         Any_press     <= |press_nx;
      end
   end

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: directed scenarios plus random bouncing keys,
// checked every cycle against a timing-rule reference model.
module tb_key_debouncer;

   localparam int NK   = 4;
   localparam int D    = 4;
   localparam int RD   = 8;
   localparam int RP   = 3;
   localparam int MAXE = 4096;

   logic          Clk = 1'b0;
   logic          Reset = 1'b1;
   logic [NK-1:0] Keys_raw = 4'hF;
   logic [NK-1:0] Keys_level;
   logic [NK-1:0] Press_pulse;
   logic [NK-1:0] Release_pulse;
   logic          Any_press;

   always #5 Clk = ~Clk;

   key_debouncer #(
      .N_KEYS(NK),
      .ACTIVE_LOW(1'b1),
      .DEBOUNCE_CYCLES(D),
      .REPEAT_EN(1'b1),
      .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .Clk(Clk),
      .Reset(Reset),
      .Keys_raw(Keys_raw),
      .Keys_level(Keys_level),
      .Press_pulse(Press_pulse),
      .Release_pulse(Release_pulse),
      .Any_press(Any_press)
   );

   int checks = 0;
   int errors = 0;

   // history indexed by edge number; lv_h[e] = level just before edge e
   bit          rst_h[MAXE];
   bit [NK-1:0] rp_h[MAXE];
   bit [NK-1:0] lv_h[MAXE+1];
   int          ra[NK];
   int          n = 0;
   int          seen0 = -1;

   // pressed-sense value the debouncer sees at edge e (two edges of sync)
   function automatic bit s2obs(int e, int c);
      if (e < 2) return 1'b0;
      if (rst_h[e-1] || rst_h[e-2]) return 1'b0;
      return rp_h[e-2][c];
   endfunction

   task automatic step(input logic [NK-1:0] raw, input logic rst);
      bit [NK-1:0] ep;
      bit [NK-1:0] er;
      bit acc, rise, rep;
      int since;
      if (n >= MAXE - 1) begin
         $display("FAIL budget edge=%0d limit=%0d", n, MAXE - 1);
         $fatal(1, "edge budget exceeded");
      end
      @(negedge Clk);
      Keys_raw = raw;
      Reset    = rst;
      @(posedge Clk);
      rst_h[n] = rst;
      rp_h[n]  = ~raw;
      ep = '0;
      er = '0;
      for (int c = 0; c < NK; c++) begin
         acc = 1'b1;
         for (int k = 0; k < D; k++) begin
            if (n - k < 0) acc = 1'b0;
            else if (rst_h[n-k]) acc = 1'b0;
            else if (s2obs(n - k, c) == lv_h[n][c]) acc = 1'b0;
            else if (lv_h[n-k][c] != lv_h[n][c]) acc = 1'b0;
         end
         lv_h[n+1][c] = rst ? 1'b0 : (acc ? ~lv_h[n][c] : lv_h[n][c]);
         if (!rst && acc && !lv_h[n][c]) ra[c] = n;
         rise  = (n > 0) && lv_h[n][c] && !lv_h[n-1][c];
         since = n - (ra[c] + 1);
         rep   = lv_h[n][c] && lv_h[n+1][c] && since >= RD &&
                 ((since - RD) % RP) == 0;
         ep[c] = !rst && (rise || rep);
         er[c] = !rst && (n > 0) && !lv_h[n][c] && lv_h[n-1][c] &&
                 !rst_h[n-1];
      end
      #1;
      assert (Keys_level === lv_h[n+1]) else begin
         errors++;
         $error("FAIL level e=%0d got %h exp %h", n, Keys_level, lv_h[n+1]);
      end
      checks++;
      assert (Press_pulse === ep) else begin
         errors++;
         $error("FAIL press e=%0d got %h exp %h", n, Press_pulse, ep);
      end
      checks++;
      assert (Release_pulse === er) else begin
         errors++;
         $error("FAIL release e=%0d got %h exp %h", n, Release_pulse, er);
      end
      checks++;
      assert (Any_press === (|ep)) else begin
         errors++;
         $error("FAIL any e=%0d got %b exp %b", n, Any_press, |ep);
      end
      checks++;
      if (Press_pulse[0] && seen0 < 0) seen0 = n;
      n++;
   endtask

   initial begin
      int e0;
      logic [NK-1:0] v;
      int hold[NK];
      for (int c = 0; c < NK; c++) begin
         ra[c]   = -1000;
         hold[c] = 0;
      end
      v = 4'hF;

      // reset then idle
      repeat (3) step(4'hF, 1'b1);
      repeat (20) step(4'hF, 1'b0);

      // single press on key 0: accept at E+5, pulse at E+6
      seen0 = -1;
      e0 = n;
      repeat (12) step(4'hE, 1'b0);
      assert (seen0 === e0 + 6) else begin
         errors++;
         $error("FAIL press0_latency got %0d exp %0d", seen0, e0 + 6);
      end
      checks++;
      repeat (10) step(4'hF, 1'b0);

      // bounce on key 1 never accepted
      repeat (3) step(4'hD, 1'b0);
      repeat (10) step(4'hF, 1'b0);

      // hold key 2 for auto-repeat, then release
      repeat (30) step(4'hB, 1'b0);
      repeat (12) step(4'hF, 1'b0);

      // keys 0 and 3 together while key 1 bounces
      for (int i = 0; i < 15; i++)
         step({1'b0, 1'b1, (i % 3) == 2, 1'b0}, 1'b0);
      repeat (10) step(4'hF, 1'b0);

      // reset while key 0 held, re-debounce after release of reset
      repeat (12) step(4'hE, 1'b0);
      step(4'hE, 1'b1);
      assert (Keys_level === 4'h0 && Press_pulse === 4'h0) else begin
         errors++;
         $error("FAIL reset_mid got %h/%h exp 0/0", Keys_level, Press_pulse);
      end
      checks++;
      step(4'hE, 1'b1);
      seen0 = -1;
      e0 = n;
      repeat (12) step(4'hE, 1'b0);
      assert (seen0 === e0 + 6) else begin
         errors++;
         $error("FAIL press0_after_reset got %0d exp %0d", seen0, e0 + 6);
      end
      checks++;
      repeat (10) step(4'hF, 1'b0);

      // random bouncing keys with occasional resets
      for (int i = 0; i < 800; i++) begin
         for (int c = 0; c < NK; c++) begin
            if (hold[c] == 0) begin
               v[c]    = $urandom_range(0, 1);
               hold[c] = $urandom_range(1, 16);
            end
            hold[c]--;
         end
         step(v, $urandom_range(0, 199) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
